// File: rtl/jam_cost_table.sv
// Cost-table stage in front of the job-assignment engine: streams in an 8x8 cost
// matrix, then serves registered (W,J) lookups. Define ROW_MIN_EN for RowMinSum.
module jam_cost_table #(
    parameter int COST_W = 7,
    parameter int IDX_W  = 3
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    Clear,
    input  logic                    In_Valid,
    output logic                    In_Ready,
    input  logic [COST_W-1:0]       In_Cost,
    input  logic [IDX_W-1:0]        W,
    input  logic [IDX_W-1:0]        J,
    output logic [COST_W-1:0]       Cost,
    output logic                    Table_Ready,
    output logic [2*IDX_W:0]        Load_Count
`ifdef ROW_MIN_EN
    ,
    output logic [COST_W+IDX_W-1:0] RowMinSum
`endif
);

    localparam int N     = 2 ** IDX_W;
    localparam int DEPTH = N * N;
    localparam logic [2*IDX_W:0] FULL = (2*IDX_W+1)'(DEPTH);

    typedef enum logic {LOAD, READY} state_e;

    state_e                 state_q, state_d;
    logic [2*IDX_W:0]       count_q, count_d;
    logic                   wr_en;
    logic [2*IDX_W-1:0]     wr_addr;
    logic [COST_W-1:0]      mem_q [DEPTH];
    logic [COST_W-1:0]      cost_q;

    assign wr_addr = count_q[2*IDX_W-1:0];

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        wr_en   = 1'b0;
        if (Clear) begin
            state_d = LOAD;
            count_d = '0;
        end else if (state_q == LOAD && In_Valid) begin
            wr_en   = 1'b1;
            count_d = count_q + 1'b1;
            if (count_q == FULL - 1'b1) begin
                state_d = READY;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= LOAD;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // NOTE: the table is a flop array because it must read as zero after reset; a RAM macro could not.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[wr_addr] <= In_Cost;
        end
    end

    // Reading the pre-edge array gives read-before-write on a same-address collision.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cost_q <= '0;
        end else begin
            cost_q <= mem_q[{W, J}];
        end
    end

    assign Cost        = cost_q;
    assign In_Ready    = (state_q == LOAD);
    assign Table_Ready = (state_q == READY);
    assign Load_Count  = count_q;

`ifdef ROW_MIN_EN
    logic [COST_W-1:0]       row_min_q;
    logic [COST_W-1:0]       row_min_cand;
    logic [COST_W+IDX_W-1:0] sum_q;

    // The first entry of a row (J==0) restarts the running minimum.
    always_comb begin
        row_min_cand = In_Cost;
        if (count_q[IDX_W-1:0] != '0 && row_min_q < In_Cost) begin
            row_min_cand = row_min_q;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            row_min_q <= '0;
            sum_q     <= '0;
        end else if (Clear) begin
            row_min_q <= '0;
            sum_q     <= '0;
        end else if (wr_en) begin
            row_min_q <= row_min_cand;
            if (count_q[IDX_W-1:0] == {IDX_W{1'b1}}) begin
                sum_q <= sum_q + (COST_W+IDX_W)'(row_min_cand);
            end
        end
    end

    assign RowMinSum = sum_q;
`endif

endmodule
